// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, oversampling constants and baud divisor helper.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  localparam int OS_RATE    = 16;
  localparam int SAMPLE_LO  = 7;
  localparam int SAMPLE_MID = 8;
  localparam int SAMPLE_HI  = 9;
  localparam int DATA_BITS  = 8;

  // clk cycles per oversample tick, rounded to nearest
  function automatic int calc_os_div(input int clk_hz, input int baud);
    return (clk_hz + baud * (OS_RATE / 2)) / (baud * OS_RATE);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: counts 0..DIV-1 while enabled and pulses tick on the wrap.
module uart_baud_tick #(
  parameter int DIV = 27
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic restart,
  output logic tick
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [W-1:0] cnt;

  assign tick = en && (cnt == W'(DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!en || restart || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/uart_rx_os16.sv
// 8N1 UART receiver with 16x oversampling, 2-of-3 majority voting and valid/ready delivery.
// Define UART_RX_PARITY_EN to receive an even parity bit and add the parity_err output.
module uart_rx_os16
  import uart_pkg::*;
#(
  parameter int CLK_HZ = 50142857,
  parameter int BAUD   = 115200,
  parameter int OS_DIV = calc_os_div(CLK_HZ, BAUD)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun,
`ifdef UART_RX_PARITY_EN
  output logic       parity_err,
`endif
  output logic       busy
);

  localparam logic [3:0] OS_LO    = 4'(SAMPLE_LO);
  localparam logic [3:0] OS_MID   = 4'(SAMPLE_MID);
  localparam logic [3:0] OS_HI    = 4'(SAMPLE_HI);
  localparam logic [3:0] OS_END   = 4'(OS_RATE - 1);
  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

  state_t                 state;
  logic                   rx_meta, rx_s, rx_s_d;
  logic                   start_fall, tick, majority;
  logic [3:0]             os_cnt;
  logic [2:0]             bit_cnt;
  logic [DATA_BITS-1:0]   shreg;
  logic                   s_lo, s_mid;
  logic                   deliver;
`ifdef UART_RX_PARITY_EN
  logic                   par_bit;
`endif

  // Synchronizer idles high so reset release never looks like a start edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_s_d  <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
      rx_s_d  <= rx_s;
    end
  end

  assign start_fall = rx_s_d & ~rx_s;
  assign majority   = (s_lo & s_mid) | (s_lo & rx_s) | (s_mid & rx_s);
  assign busy       = (state != IDLE);

  uart_baud_tick #(
    .DIV(OS_DIV)
  ) u_tick (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (state != IDLE),
    .restart((state == IDLE) && start_fall),
    .tick   (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      os_cnt    <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      s_lo      <= 1'b1;
      s_mid     <= 1'b1;
      deliver   <= 1'b0;
      frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit   <= 1'b0;
`endif
    end else begin
      deliver   <= 1'b0;
      frame_err <= 1'b0;
      if (state == IDLE) begin
        os_cnt  <= '0;
        bit_cnt <= '0;
        if (start_fall) state <= START;
      end else if (tick) begin
        os_cnt <= os_cnt + 4'd1;
        if (os_cnt == OS_LO)  s_lo  <= rx_s;
        if (os_cnt == OS_MID) s_mid <= rx_s;
        case (state)
          START: begin
            if (os_cnt == OS_HI && majority) state <= IDLE;
            else if (os_cnt == OS_END)       state <= DATA;
          end
          DATA: begin
            if (os_cnt == OS_HI) shreg <= {majority, shreg[DATA_BITS-1:1]};
            if (os_cnt == OS_END) begin
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                state <= PARITY;
`else
                state <= STOP;
`endif
              end
            end
          end
`ifdef UART_RX_PARITY_EN
          PARITY: begin
            if (os_cnt == OS_HI)  par_bit <= majority;
            if (os_cnt == OS_END) state   <= STOP;
          end
`endif
          // Leave at mid-stop so a back-to-back start edge is not missed
          STOP: begin
            if (os_cnt == OS_HI) begin
              state <= IDLE;
              if (majority) deliver   <= 1'b1;
              else          frame_err <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      overrun    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
    end else begin
`ifdef UART_RX_PARITY_EN
      parity_err <= deliver && (^{shreg, par_bit});
`endif
      if (deliver) begin
        rx_data  <= shreg;
        rx_valid <= 1'b1;
        if (rx_valid && !rx_ready) overrun <= 1'b1;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/uart_rx_os16.md
Name: uart_rx_os16

Overview:
UART receiver for the UART datapath, clocked by the 50.142857 MHz PLL output clock (27 MHz × 13 / 7).
- Recovers 8N1 frames from the asynchronous rx line using 16x oversampling with majority-vote sampling.
- Delivers each byte through a valid/ready handshake to the downstream consumer (echo logic or FIFO).
- Flags framing and overrun errors.

Parameters:
- CLK_HZ, 50142857, frequency of clk in Hz.
- BAUD, 115200, line bit rate.
- OS_DIV, CLK_HZ/(BAUD*16) rounded to nearest (27 at defaults), clk cycles per oversample tick; must be ≥2.

Ports:
- clk  in  1  PLL output clock, rising edge.
- rst_n  in  1  async assert, active-low reset; deassertion is synchronous to clk.
- rx  in  1  serial line, idle high, asynchronous to clk.
- rx_data  out  8  received byte, LSB = first data bit.
- rx_valid  out  1  rx_data holds an unconsumed byte.
- rx_ready  in  1  consumer accepts when rx_valid && rx_ready at a clk edge.
- frame_err  out  1  one-cycle pulse: stop bit sampled low.
- overrun  out  1  sticky; a new byte completed while rx_valid was still high. Cleared only by reset.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset values: rx_data=0, rx_valid=0, frame_err=0, overrun=0, busy=0, FSM=IDLE. Synchronizer flops reset to 1.
- Input path: rx passes through a 2-flop synchronizer (rx_s); start-edge detection adds 2 cycles of latency.
- Tick generator: counter 0..OS_DIV-1 that pulses tick on wrap. It is held at 0 in IDLE and restarts on the falling edge that enters START.
- Oversample counter os_cnt is 4 bits and wraps 15→0.
  - Samples are taken at os_cnt 7, 8 and 9.
  - The bit value is the 2-of-3 majority, latched at os_cnt=9.
  - The bit ends at os_cnt=15.
- FSM states and transitions:
  - IDLE: on rx_s 1→0 go to START.
  - START: the majority at mid-bit must be 0, otherwise it is a glitch and the FSM returns to IDLE with no error. A valid start goes to DATA at the bit end.
  - DATA: shift the majority into a shift register, LSB first. A 3-bit counter tracks bits; after bit 7 the FSM goes to STOP (or PARITY, see Optional Feature).
  - STOP: at mid-stop (os_cnt=9) evaluate the stop-bit majority and go to IDLE immediately, not at the bit end, so back-to-back frames are caught.
    - Majority 1: the byte is delivered.
    - Majority 0: frame_err pulses for 1 cycle and nothing is delivered.
- Delivery happens in the cycle after the STOP decision:
  - rx_data ← shift register and rx_valid ← 1.
  - If rx_valid was already 1 without a handshake in that cycle: overrun ← 1 and the new byte overwrites rx_data.
  - If a handshake and a delivery occur in the same cycle: rx_valid stays 1 with the new data and there is no overrun.
- Handshake: rx_valid drops the cycle after rx_valid && rx_ready unless a delivery coincides. rx_data is stable while rx_valid=1 and no delivery occurs.
- Latency: rx_valid rises about 9.5 bit times plus 3 clk after the start falling edge.
- A break condition (rx held low) produces one frame_err per frame. A new frame only begins after rx_s returns high and then falls again.
- Reset asserted mid-frame aborts immediately to IDLE with all outputs at reset values; the partial byte is discarded.

Optional Feature:
- Macro UART_RX_PARITY_EN.
- Defined:
  - Adds a PARITY state between DATA and STOP that samples a 9th bit; even parity is checked over data plus the parity bit.
  - Adds output parity_err (1 bit), a one-cycle pulse concurrent with the delivery cycle. The byte is still delivered.
- Undefined: frame is 8N1; there is no parity_err port and no PARITY state.

Decomposition:
- Package uart_pkg holds:
  - State enum (IDLE, START, DATA, PARITY, STOP).
  - Constants OS_RATE=16, SAMPLE_LO=7, SAMPLE_MID=8, SAMPLE_HI=9, DATA_BITS=8.
  - A function computing OS_DIV from CLK_HZ and BAUD.
- Sub-module uart_baud_tick (counter plus enable/restart) is reusable by the future transmitter. The synchronizer stays inline.

Test Plan:
- Byte 0x55 at 115200 baud, rx_ready=1 → one rx_valid pulse with rx_data=0x55, frame_err=0, overrun=0.
- Bytes 0xA3 then 0x0F back-to-back (no idle gap), rx_ready=0 → after the first byte rx_valid=1 with 0xA3; after the second, overrun=1, rx_data=0x0F, rx_valid=1.
- Frame 0xC4 with the stop bit forced low → frame_err one-cycle pulse, rx_valid stays 0; the following good frame 0x12 is delivered normally.
- 1-clk and 3-tick low glitches on an idle line → no state exit past START, no rx_valid, no frame_err. Byte 0x81 with a single-sample-wide (1 tick) inverted glitch at os_cnt=8 of bit 3 → still received as 0x81.
- Baud mismatch: transmitter at BAUD+2% and at BAUD−2%, byte 0xFF and 0x00 → both received correctly.
- rst_n asserted for 5 clk during bit 4 of 0x6B, then byte 0x3C sent → no output for 0x6B; 0x3C delivered; all outputs are 0 during reset.
- With UART_RX_PARITY_EN defined: 0x07 with parity bit 0 → rx_data=0x07 with parity_err=1.
